sseg_scan_decoder: RTL and testbench

Receive-side counterpart of the stopwatch display driver. Watches the multiplexed four-digit seven-segment bus (`an`, `sseg`, `dp`) and reconstructs the displayed digits into registered binary values, once per complete scan frame. Used in on-board self-check and readback paths, and as a bench monitor for display-producing blocks.

---
 rtl/sseg_scan_decoder_if.sv | 24 ++
 rtl/sseg_scan_decoder.sv | 266 ++++++++++++++++++++++++++
 tb/tb_sseg_scan_decoder.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sseg_scan_decoder_if.sv
// -----------------------------------------------------------------------------
// sseg_scan_decoder_if
//
// Purpose: bundles the multiplexed four-digit seven-segment display bus so that
// a display producer (master) and the scan decoder (slave) can be connected
// with a single port.
//
// Signals (all active-low, as seen on the display pins):
//   an   [3:0] : anode enables, an[0] selects digit 0 (rightmost)
//   sseg [6:0] : segment bus, {g,f,e,d,c,b,a}
//   dp         : decimal point
//
// Modports:
//   master : drives the bus (display driver, testbench)
//   slave  : observes the bus (sseg_scan_decoder)
// -----------------------------------------------------------------------------
interface sseg_scan_decoder_if;
   logic [3:0] an;
   logic [6:0] sseg;
   logic       dp;

   modport master (output an, output sseg, output dp);
   modport slave  (input  an, input  sseg, input  dp);
endinterface

// File: rtl/sseg_scan_decoder.sv
// -----------------------------------------------------------------------------
// sseg_scan_decoder
//
// Purpose: watches a multiplexed four-digit seven-segment bus and rebuilds the
// displayed digits as registered binary values, committing them once per
// complete scan frame. Intended for on-board self-check/readback and as a
// monitor for display-producing blocks.
//
// Parameters:
//   SETTLE  : cycles the anode code must remain stable before its segments are
//             sampled (minimum 1)
//   TIMEOUT : cycles without a digit capture before scan_lost asserts
//             (compared against a 16-bit saturating counter)
//
// Ports:
//   clk          : single clock, rising edge
//   R            : synchronous reset, active-low
//   bus          : display bus (an, sseg, dp), slave modport
//   digit0..3    : decoded digit values of the last committed frame
//   dp_out       : per-digit decimal point, active-high
//   blank        : per digit, all segments off
//   bad          : per digit, segment pattern not decodable
//   frame_valid  : one-cycle pulse when a new frame is committed
//   frame_change : one-cycle pulse with frame_valid when the committed frame
//                  differs from the previous one
//   err_an       : one-cycle pulse when an illegal anode code is observed
//   scan_lost    : level, the scan has stalled
//
// Build option:
//   SSEG_DEC_HEX_EN : when defined, the patterns for A-F decode as values
//                     10-15; when undefined they are reported as bad.
// -----------------------------------------------------------------------------
module sseg_scan_decoder #(
   parameter int SETTLE  = 4,
   parameter int TIMEOUT = 50000
) (
   input  logic               clk,
   input  logic               R,
   sseg_scan_decoder_if.slave bus,
   output logic [3:0]         digit0,
   output logic [3:0]         digit1,
   output logic [3:0]         digit2,
   output logic [3:0]         digit3,
   output logic [3:0]         dp_out,
   output logic [3:0]         blank,
   output logic [3:0]         bad,
   output logic               frame_valid,
   output logic               frame_change,
   output logic               err_an,
   output logic               scan_lost
);

   localparam int            CW        = $clog2(SETTLE + 1);
   localparam logic [CW-1:0] SETTLE_C  = CW'(SETTLE);
   localparam logic [CW-1:0] ONE_C     = CW'(1);
   localparam logic [15:0]   TIMEOUT_C = 16'(TIMEOUT);

   localparam logic [0:0] ST_COLLECT = 1'b0;
   localparam logic [0:0] ST_COMMIT  = 1'b1;

   // Exactly one anode driven (low).
   function automatic logic onehot_low(input logic [3:0] a);
      logic [3:0] n;
      n = ~a;
      return (n != 4'd0) && ((n & (n - 4'd1)) == 4'd0);
   endfunction

   // Two or more anodes driven at once.
   function automatic logic illegal_code(input logic [3:0] a);
      return (a != 4'hF) && !onehot_low(a);
   endfunction

   function automatic logic [CW-1:0] sat_inc_settle(input logic [CW-1:0] v);
      return (v == SETTLE_C) ? v : v + ONE_C;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Result layout: {bad, blank, value[3:0]}.
   function automatic logic [5:0] decode_seg(input logic [6:0] s);
      logic [5:0] r;
      r = 6'b10_0000;
      case (s)
         7'h40: r = {2'b00, 4'd0};
         7'h79: r = {2'b00, 4'd1};
         7'h24: r = {2'b00, 4'd2};
         7'h30: r = {2'b00, 4'd3};
         7'h19: r = {2'b00, 4'd4};
         7'h12: r = {2'b00, 4'd5};
         7'h02: r = {2'b00, 4'd6};
         7'h78: r = {2'b00, 4'd7};
         7'h00: r = {2'b00, 4'd8};
         7'h10: r = {2'b00, 4'd9};
         7'h7F: r = 6'b01_0000;
`ifdef SSEG_DEC_HEX_EN
         7'h08: r = {2'b00, 4'd10};
         7'h03: r = {2'b00, 4'd11};
         7'h46: r = {2'b00, 4'd12};
         7'h21: r = {2'b00, 4'd13};
         7'h06: r = {2'b00, 4'd14};
         7'h0E: r = {2'b00, 4'd15};
`endif
         default: r = 6'b10_0000;
      endcase
      return r;
   endfunction

   // Input register
   logic [3:0]          an_q, an_d;
   logic [6:0]          sseg_q, sseg_d;
   logic                dp_q, dp_d;
   logic                chg_q, chg_d;

   // Dwell tracking, capture and frame assembly
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [15:0]         to_cnt_q, to_cnt_d;
   logic                lost_q, lost_d;
   logic                err_q, err_d;
   logic [0:0]          state_q, state_d;
   logic [3:0]          mask_q, mask_d;
   logic [3:0][3:0]     stg_val_q, stg_val_d;
   logic [3:0]          stg_dp_q, stg_dp_d;
   logic [3:0]          stg_blank_q, stg_blank_d;
   logic [3:0]          stg_bad_q, stg_bad_d;

   // Committed frame
   logic [3:0][3:0]     dig_q, dig_d;
   logic [3:0]          dp_out_q, dp_out_d;
   logic [3:0]          blank_q, blank_d;
   logic [3:0]          bad_q, bad_d;
   logic                fv_q, fv_d;
   logic                fc_q, fc_d;

   logic                capture;
   logic [5:0]          dec;

   always_comb begin
      an_d   = bus.an;
      sseg_d = bus.sseg;
      dp_d   = bus.dp;

      // The stability counter restarts on the same edge that loads a new code
      // into an_q, so it reads k exactly k edges into the dwell and the capture
      // lands SETTLE edges after the code first appears in an_q.
      chg_d = (an_d != an_q);
      cnt_d = chg_d ? '0 : sat_inc_settle(cnt_q);

      // Fires only on the transition into SETTLE: one capture per dwell.
      capture = onehot_low(an_q) && (cnt_d == SETTLE_C) && (cnt_q != SETTLE_C);

      // chg_q marks the first cycle a code sits in an_q, so a held illegal
      // code pulses once; a change to another illegal code pulses again.
      err_d = chg_q && illegal_code(an_q);

      dec = decode_seg(sseg_q);

      stg_val_d   = stg_val_q;
      stg_dp_d    = stg_dp_q;
      stg_blank_d = stg_blank_q;
      stg_bad_d   = stg_bad_q;
      for (int i = 0; i < 4; i++) begin
         if (capture && !an_q[i]) begin
            stg_val_d[i]   = dec[3:0];
            stg_dp_d[i]    = ~dp_q;
            stg_blank_d[i] = dec[4];
            stg_bad_d[i]   = dec[5];
         end
      end

      to_cnt_d = capture ? '0 : sat_inc16(to_cnt_q);
      lost_d   = (to_cnt_d >= TIMEOUT_C);

      state_d  = state_q;
      mask_d   = mask_q;
      dig_d    = dig_q;
      dp_out_d = dp_out_q;
      blank_d  = blank_q;
      bad_d    = bad_q;
      fv_d     = 1'b0;
      fc_d     = 1'b0;

      case (state_q)
         ST_COLLECT: begin
            if (mask_q == 4'hF) state_d = ST_COMMIT;
         end
         ST_COMMIT: begin
            dig_d    = stg_val_q;
            dp_out_d = stg_dp_q;
            blank_d  = stg_blank_q;
            bad_d    = stg_bad_q;
            fv_d     = 1'b1;
            fc_d     = ({stg_val_q, stg_dp_q, stg_blank_q, stg_bad_q} !=
                        {dig_q, dp_out_q, blank_q, bad_q});
            mask_d   = '0;
            state_d  = ST_COLLECT;
         end
         default: state_d = ST_COLLECT;
      endcase

      // An illegal code throws away the partial frame. A capture landing in
      // the commit cycle is applied after the clear so it opens the next frame.
      if (err_d)   mask_d = '0;
      if (capture) mask_d = mask_d | ~an_q;
   end

   always_ff @(posedge clk) begin
      if (!R) begin
         an_q        <= 4'hF;
         sseg_q      <= 7'h7F;
         dp_q        <= 1'b1;
         chg_q       <= 1'b0;
         cnt_q       <= '0;
         to_cnt_q    <= '0;
         lost_q      <= 1'b0;
         err_q       <= 1'b0;
         state_q     <= ST_COLLECT;
         mask_q      <= '0;
         stg_val_q   <= '0;
         stg_dp_q    <= '0;
         stg_blank_q <= 4'hF;
         stg_bad_q   <= '0;
         dig_q       <= '0;
         dp_out_q    <= '0;
         blank_q     <= 4'hF;
         bad_q       <= '0;
         fv_q        <= 1'b0;
         fc_q        <= 1'b0;
      end else begin
         an_q        <= an_d;
         sseg_q      <= sseg_d;
         dp_q        <= dp_d;
         chg_q       <= chg_d;
         cnt_q       <= cnt_d;
         to_cnt_q    <= to_cnt_d;
         lost_q      <= lost_d;
         err_q       <= err_d;
         state_q     <= state_d;
         mask_q      <= mask_d;
         stg_val_q   <= stg_val_d;
         stg_dp_q    <= stg_dp_d;
         stg_blank_q <= stg_blank_d;
         stg_bad_q   <= stg_bad_d;
         dig_q       <= dig_d;
         dp_out_q    <= dp_out_d;
         blank_q     <= blank_d;
         bad_q       <= bad_d;
         fv_q        <= fv_d;
         fc_q        <= fc_d;
      end
   end

   assign digit0       = dig_q[0];
   assign digit1       = dig_q[1];
   assign digit2       = dig_q[2];
   assign digit3       = dig_q[3];
   assign dp_out       = dp_out_q;
   assign blank        = blank_q;
   assign bad          = bad_q;
   assign frame_valid  = fv_q;
   assign frame_change = fc_q;
   assign err_an       = err_q;
   assign scan_lost    = lost_q;

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_sseg_scan_decoder
//
// Purpose: directed self-checking bench for sseg_scan_decoder (SETTLE=4,
// TIMEOUT=100). Inputs change on the falling clock edge and outputs are
// sampled on the falling edge. Expected results follow SSEG_DEC_HEX_EN.
// -----------------------------------------------------------------------------
module tb_sseg_scan_decoder;
   localparam int SETTLE  = 4;
   localparam int TIMEOUT = 100;

   logic       clk = 1'b0;
   logic       R   = 1'b0;
   logic [3:0] digit0, digit1, digit2, digit3;
   logic [3:0] dp_out, blank, bad;
   logic       frame_valid, frame_change, err_an, scan_lost;

   int checks = 0;
   int errors = 0;

   // Pulse counters and pulse-shape violations, written only by the monitor.
   int   fv_cnt = 0, fc_cnt = 0, err_cnt = 0, shape_viol = 0;
   logic fv_prev = 1'b0, err_prev = 1'b0;

   sseg_scan_decoder_if bus ();

   sseg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .R            (R),
      .bus          (bus),
      .digit0       (digit0),
      .digit1       (digit1),
      .digit2       (digit2),
      .digit3       (digit3),
      .dp_out       (dp_out),
      .blank        (blank),
      .bad          (bad),
      .frame_valid  (frame_valid),
      .frame_change (frame_change),
      .err_an       (err_an),
      .scan_lost    (scan_lost)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_valid === 1'b1) fv_cnt++;
      if (frame_change === 1'b1) fc_cnt++;
      if (err_an === 1'b1) err_cnt++;
      if (frame_valid === 1'b1 && fv_prev === 1'b1) shape_viol++;
      if (err_an === 1'b1 && err_prev === 1'b1) shape_viol++;
      if (frame_change === 1'b1 && frame_valid !== 1'b1) shape_viol++;
      fv_prev  = frame_valid;
      err_prev = err_an;
   end

   function automatic logic [6:0] seg(input int d);
      case (d)
         0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
         4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
         8: return 7'h00;  9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   // Called at a falling edge; holds the pattern for n sampling edges.
   task automatic drive(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
      bus.an   = a;
      bus.sseg = s;
      bus.dp   = d;
      repeat (n) @(negedge clk);
   endtask

   task automatic scan4(input int d0, input int d1, input int d2, input int d3,
                        input logic [3:0] dpm, input int n);
      drive(4'b1110, seg(d0), ~dpm[0], n);
      drive(4'b1101, seg(d1), ~dpm[1], n);
      drive(4'b1011, seg(d2), ~dpm[2], n);
      drive(4'b0111, seg(d3), ~dpm[3], n);
   endtask

   task automatic test_reset;
      R = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({digit3, digit2, digit1, digit0} !== 16'h0000) begin
         errors++; $display("FAIL reset_digits: got %h want 0000", {digit3, digit2, digit1, digit0});
      end
      checks++;
      if ({dp_out, blank, bad} !== 12'h0F0) begin
         errors++; $display("FAIL reset_flags: got %h want 0f0", {dp_out, blank, bad});
      end
      checks++;
      if ({frame_valid, frame_change, err_an, scan_lost} !== 4'b0000) begin
         errors++; $display("FAIL reset_pulses: got %b want 0000", {frame_valid, frame_change, err_an, scan_lost});
      end
      R = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_steady_scan;
      int fv0, fc0;
      fv0 = fv_cnt; fc0 = fc_cnt;
      scan4(1, 2, 3, 4, 4'b0100, 8);
      checks++;
      if (fv_cnt - fv0 !== 1) begin
         errors++; $display("FAIL steady_fv1: got %0d want 1", fv_cnt - fv0);
      end
      checks++;
      if (fc_cnt - fc0 !== 1) begin
         errors++; $display("FAIL steady_fc1: got %0d want 1", fc_cnt - fc0);
      end
      checks++;
      if ({digit3, digit2, digit1, digit0} !== 16'h4321) begin
         errors++; $display("FAIL steady_digits: got %h want 4321", {digit3, digit2, digit1, digit0});
      end
      checks++;
      if ({dp_out, blank, bad} !== 12'h400) begin
         errors++; $display("FAIL steady_flags: got %h want 400", {dp_out, blank, bad});
      end
      fv0 = fv_cnt; fc0 = fc_cnt;
      scan4(1, 2, 3, 4, 4'b0100, 8);
      checks++;
      if (fv_cnt - fv0 !== 1) begin
         errors++; $display("FAIL steady_fv2: got %0d want 1", fv_cnt - fv0);
      end
      checks++;
      if (fc_cnt - fc0 !== 0) begin
         errors++; $display("FAIL steady_fc2: got %0d want 0", fc_cnt - fc0);
      end
   endtask

   task automatic test_digit_change;
      int fv0, fc0;
      fv0 = fv_cnt; fc0 = fc_cnt;
      scan4(1, 7, 3, 4, 4'b0100, 8);
      checks++;
      if ({digit3, digit2, digit1, digit0} !== 16'h4371) begin
         errors++; $display("FAIL change_digits: got %h want 4371", {digit3, digit2, digit1, digit0});
      end
      checks++;
      if (fv_cnt - fv0 !== 1 || fc_cnt - fc0 !== 1) begin
         errors++; $display("FAIL change_pulses: got fv %0d fc %0d want 1 1", fv_cnt - fv0, fc_cnt - fc0);
      end
      fv0 = fv_cnt; fc0 = fc_cnt;
      scan4(1, 7, 3, 4, 4'b0100, 8);
      checks++;
      if (fv_cnt - fv0 !== 1 || fc_cnt - fc0 !== 0) begin
         errors++; $display("FAIL same_pulses: got fv %0d fc %0d want 1 0", fv_cnt - fv0, fc_cnt - fc0);
      end
   endtask

   task automatic test_illegal_anode;
      int fv0, fc0, e0;
      fv0 = fv_cnt; fc0 = fc_cnt; e0 = err_cnt;
      drive(4'b1110, seg(2), 1'b1, 8);
      drive(4'b1101, seg(2), 1'b1, 8);
      drive(4'b0011, seg(0), 1'b1, 1);
      checks++;
      if (err_an !== 1'b0) begin
         errors++; $display("FAIL err_early: got %b want 0", err_an);
      end
      @(negedge clk);
      checks++;
      if (err_an !== 1'b1) begin
         errors++; $display("FAIL err_timing: got %b want 1", err_an);
      end
      @(negedge clk);
      checks++;
      if (err_an !== 1'b0) begin
         errors++; $display("FAIL err_width: got %b want 0", err_an);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (err_cnt - e0 !== 1) begin
         errors++; $display("FAIL err_once: got %0d want 1", err_cnt - e0);
      end
      drive(4'b0101, seg(0), 1'b1, 3);
      checks++;
      if (err_cnt - e0 !== 2) begin
         errors++; $display("FAIL err_repulse: got %0d want 2", err_cnt - e0);
      end
      drive(4'b1011, seg(5), 1'b1, 8);
      drive(4'b0111, seg(6), 1'b1, 8);
      checks++;
      if (fv_cnt - fv0 !== 0) begin
         errors++; $display("FAIL err_discard: got %0d frames want 0", fv_cnt - fv0);
      end
      drive(4'b1110, seg(8), 1'b1, 8);
      drive(4'b1101, seg(9), 1'b1, 8);
      checks++;
      if (fv_cnt - fv0 !== 1 || fc_cnt - fc0 !== 1) begin
         errors++; $display("FAIL err_refill: got fv %0d fc %0d want 1 1", fv_cnt - fv0, fc_cnt - fc0);
      end
      checks++;
      if ({digit3, digit2, digit1, digit0} !== 16'h6598) begin
         errors++; $display("FAIL err_digits: got %h want 6598", {digit3, digit2, digit1, digit0});
      end
   endtask

   task automatic test_short_dwell_blank;
      int fv0;
      fv0 = fv_cnt;
      drive(4'b1110, seg(1), 1'b1, 3);
      drive(4'b1101, seg(1), 1'b1, 3);
      drive(4'b1011, seg(1), 1'b1, 3);
      drive(4'b0111, seg(1), 1'b1, 3);
      drive(4'b1111, 7'h7F, 1'b1, 8);
      checks++;
      if (fv_cnt - fv0 !== 0 || {digit3, digit2, digit1, digit0} !== 16'h6598) begin
         errors++; $display("FAIL short_dwell: got fv %0d digits %h want 0 6598", fv_cnt - fv0, {digit3, digit2, digit1, digit0});
      end
      fv0 = fv_cnt;
      drive(4'b1110, 7'h7F,  1'b1, 8);
      drive(4'b1111, 7'h7F,  1'b1, 3);
      drive(4'b1101, 7'h55,  1'b1, 8);
      drive(4'b1111, 7'h7F,  1'b1, 3);
      drive(4'b1011, seg(3), 1'b1, 8);
      drive(4'b1111, 7'h7F,  1'b1, 3);
      drive(4'b0111, seg(0), 1'b1, 8);
      drive(4'b1111, 7'h7F,  1'b1, 4);
      checks++;
      if (fv_cnt - fv0 !== 1) begin
         errors++; $display("FAIL gap_frame: got %0d want 1", fv_cnt - fv0);
      end
      checks++;
      if ({digit3, digit2, digit1, digit0} !== 16'h0300) begin
         errors++; $display("FAIL gap_digits: got %h want 0300", {digit3, digit2, digit1, digit0});
      end
      checks++;
      if ({dp_out, blank, bad} !== 12'h012) begin
         errors++; $display("FAIL blank_bad: got %h want 012", {dp_out, blank, bad});
      end
   endtask

   task automatic test_scan_loss;
      int fv0, fc0;
      fv0 = fv_cnt; fc0 = fc_cnt;
      // Digit 0 is captured on the 5th edge; scan_lost follows 100 edges later.
      drive(4'b1110, seg(2), 1'b1, 104);
      checks++;
      if (scan_lost !== 1'b0) begin
         errors++; $display("FAIL lost_early: got %b want 0", scan_lost);
      end
      @(negedge clk);
      checks++;
      if (scan_lost !== 1'b1) begin
         errors++; $display("FAIL lost_rise: got %b want 1", scan_lost);
      end
      repeat (20) @(negedge clk);
      checks++;
      if (scan_lost !== 1'b1 || fv_cnt - fv0 !== 0 || {digit3, digit2, digit1, digit0} !== 16'h0300) begin
         errors++; $display("FAIL lost_hold: got lost %b fv %0d digits %h want 1 0 0300", scan_lost, fv_cnt - fv0, {digit3, digit2, digit1, digit0});
      end
      drive(4'b1101, seg(4), 1'b1, 4);
      checks++;
      if (scan_lost !== 1'b1) begin
         errors++; $display("FAIL lost_before_capture: got %b want 1", scan_lost);
      end
      @(negedge clk);
      checks++;
      if (scan_lost !== 1'b0) begin
         errors++; $display("FAIL lost_clear: got %b want 0", scan_lost);
      end
      repeat (3) @(negedge clk);
      drive(4'b1011, seg(6), 1'b1, 8);
      drive(4'b0111, seg(8), 1'b1, 8);
      checks++;
      if (fv_cnt - fv0 !== 1 || fc_cnt - fc0 !== 1 || {digit3, digit2, digit1, digit0} !== 16'h8642) begin
         errors++; $display("FAIL lost_resume: got fv %0d fc %0d digits %h want 1 1 8642", fv_cnt - fv0, fc_cnt - fc0, {digit3, digit2, digit1, digit0});
      end
   endtask

   task automatic test_reset_mid_frame;
      int fv0;
      fv0 = fv_cnt;
      drive(4'b1110, seg(9), 1'b1, 8);
      drive(4'b1101, seg(9), 1'b1, 8);
      bus.an = 4'b1011; bus.sseg = seg(0); bus.dp = 1'b1;
      R = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({digit3, digit2, digit1, digit0, dp_out, blank, bad} !== 28'h00000F0) begin
         errors++; $display("FAIL midreset_outputs: got %h want 00000f0", {digit3, digit2, digit1, digit0, dp_out, blank, bad});
      end
      R = 1'b1;
      repeat (8) @(negedge clk);
      drive(4'b0111, seg(0), 1'b1, 8);
      checks++;
      if (fv_cnt - fv0 !== 0 || blank !== 4'hF) begin
         errors++; $display("FAIL midreset_noframe: got fv %0d blank %h want 0 f", fv_cnt - fv0, blank);
      end
   endtask

   task automatic test_hex_decode;
      int fv0, fc0;
      logic [15:0] exp_dig;
      logic [11:0] exp_flags;
`ifdef SSEG_DEC_HEX_EN
      exp_dig   = 16'h000A;
      exp_flags = 12'h000;
`else
      exp_dig   = 16'h0000;
      exp_flags = 12'h001;
`endif
      fv0 = fv_cnt; fc0 = fc_cnt;
      // Digits 2 and 3 were captured after the reset; these complete the frame.
      drive(4'b1110, 7'h08,  1'b1, 8);
      drive(4'b1101, seg(0), 1'b1, 8);
      checks++;
      if (fv_cnt - fv0 !== 1 || fc_cnt - fc0 !== 1) begin
         errors++; $display("FAIL hex_pulses: got fv %0d fc %0d want 1 1", fv_cnt - fv0, fc_cnt - fc0);
      end
      checks++;
      if ({digit3, digit2, digit1, digit0} !== exp_dig) begin
         errors++; $display("FAIL hex_digits: got %h want %h", {digit3, digit2, digit1, digit0}, exp_dig);
      end
      checks++;
      if ({dp_out, blank, bad} !== exp_flags) begin
         errors++; $display("FAIL hex_flags: got %h want %h", {dp_out, blank, bad}, exp_flags);
      end
   endtask

   task automatic test_pulse_shape;
      checks++;
      if (shape_viol !== 0) begin
         errors++; $display("FAIL pulse_shape: got %0d violations want 0", shape_viol);
      end
   endtask

   initial begin
      bus.an   = 4'hF;
      bus.sseg = 7'h7F;
      bus.dp   = 1'b1;
      test_reset;
      test_steady_scan;
      test_digit_change;
      test_illegal_anode;
      test_short_dwell_blank;
      test_scan_loss;
      test_reset_mid_frame;
      test_hex_decode;
      test_pulse_shape;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
